// File: rtl/rt_frame_sequencer.sv
// Frame sequencer: walks RTcore over every pixel, packs four 4-bit pixels per
// framebuffer word into the back bank and requests a bank swap per frame.
// Optional RTcore watchdog enabled by defining RTSEQ_TIMEOUT_EN.
module rt_frame_sequencer #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int FB_ADDR_W = 17
`ifdef RTSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 4096
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 STOP,
    output logic                 RT_ENABLE,
    output logic [9:0]           RT_X,
    output logic [8:0]           RT_Y,
    input  logic                 RT_READY,
    input  logic [3:0]           RT_PIXEL,
    output logic                 FB_WE,
    output logic [FB_ADDR_W:0]   FB_ADDR,
    output logic [15:0]          FB_WDATA,
    input  logic                 FB_BUSY,
    output logic                 SWAP_REQ,
    input  logic                 SWAP_ACK,
    output logic                 DISP_BANK,
    output logic                 FRAME_DONE,
    output logic [15:0]          FRAME_CNT,
    output logic                 ERR_TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, WRITE, SWAP
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [9:0]             x;
    logic [8:0]             y;
    logic [FB_ADDR_W-1:0]   word_addr;
    logic [15:0]            pack_reg;
    logic                   stop_latch;
    logic                   disp_bank;
    logic                   frame_done;
    logic [15:0]            frame_cnt;
    logic                   pixel_timeout;
    logic                   capture;
    logic                   write_done;
    logic                   swap_done;
    logic                   last_pixel;
    logic                   last_lane;
    logic [3:0]             cap_pixel;

`ifdef RTSEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0]        to_cnt;
    logic                   err_timeout;

    // Watchdog only fires while RTcore still owes us the pixel.
    assign pixel_timeout = (state == WAIT_BUSY || (state == WAIT_DONE && !RT_READY))
                           && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT_BUSY || state == WAIT_DONE)
                to_cnt <= to_cnt + TO_W'(1);
            if (pixel_timeout)
                err_timeout <= 1'b1;
        end
    end

    assign ERR_TIMEOUT = err_timeout;
`else
    assign pixel_timeout = 1'b0;
    assign ERR_TIMEOUT   = 1'b0;
`endif

    assign capture    = (state == WAIT_DONE && RT_READY) || pixel_timeout;
    assign cap_pixel  = pixel_timeout ? 4'hC : RT_PIXEL;
    assign write_done = (state == WRITE) && !FB_BUSY;
    assign swap_done  = (state == SWAP) && SWAP_ACK;
    assign last_lane  = (x[1:0] == 2'd3);
    assign last_pixel = (x == 10'(H_RES - 1)) && (y == 9'(V_RES - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (START) next_state = ISSUE;
            ISSUE:     if (RT_READY) next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (capture)
                    next_state = last_lane ? WRITE : ISSUE;
                else if (!RT_READY)
                    next_state = WAIT_DONE;
            end
            WAIT_DONE: if (capture) next_state = last_lane ? WRITE : ISSUE;
            WRITE:     if (!FB_BUSY) next_state = last_pixel ? SWAP : ISSUE;
            SWAP:      if (SWAP_ACK) next_state = (stop_latch || STOP) ? IDLE : ISSUE;
            default:   next_state = IDLE;
        endcase
    end

    // Pixel walk, packing and frame bookkeeping; the enables are mutually exclusive.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x          <= '0;
            y          <= '0;
            word_addr  <= '0;
            pack_reg   <= '0;
            stop_latch <= 1'b0;
            disp_bank  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= swap_done;
            stop_latch <= swap_done ? 1'b0 : (stop_latch || STOP);
            if (state == IDLE && START) begin
                x         <= '0;
                y         <= '0;
                word_addr <= '0;
            end else if (capture) begin
                pack_reg[{x[1:0], 2'b00} +: 4] <= cap_pixel;
                if (!last_lane)
                    x <= x + 10'd1;
            end else if (write_done) begin
                word_addr <= word_addr + FB_ADDR_W'(1);
                if (x == 10'(H_RES - 1)) begin
                    x <= '0;
                    if (y != 9'(V_RES - 1))
                        y <= y + 9'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end else if (swap_done) begin
                disp_bank <= ~disp_bank;
                frame_cnt <= frame_cnt + 16'd1;
                x         <= '0;
                y         <= '0;
                word_addr <= '0;
            end
        end
    end

    always_comb begin
        RT_ENABLE = (state == ISSUE) && RT_READY;
        FB_WE     = (state == WRITE);
        FB_ADDR   = '0;
        FB_WDATA  = '0;
        SWAP_REQ  = (state == SWAP);
        if (state == WRITE) begin
            FB_ADDR  = {~disp_bank, word_addr};
            FB_WDATA = pack_reg;
        end
    end

    assign RT_X       = x;
    assign RT_Y       = y;
    assign DISP_BANK  = disp_bank;
    assign FRAME_DONE = frame_done;
    assign FRAME_CNT  = frame_cnt;

endmodule

// File: tb/tb_rt_frame_sequencer.sv
// Bench for rt_frame_sequencer: 8x2 frame, behavioural RTcore returning pixel=X,
// scoreboard of expected framebuffer writes. Timeout case runs with RTSEQ_TIMEOUT_EN.
module tb_rt_frame_sequencer;

    localparam int H_RES = 8;
    localparam int V_RES = 2;
    localparam int FB_ADDR_W = 2;
    localparam int RT_LAT = 5;
    localparam int HANG_LAT = 40;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic START = 1'b0;
    logic STOP = 1'b0;
    logic RT_ENABLE;
    logic [9:0] RT_X;
    logic [8:0] RT_Y;
    logic RT_READY;
    logic [3:0] RT_PIXEL;
    logic FB_WE;
    logic [FB_ADDR_W:0] FB_ADDR;
    logic [15:0] FB_WDATA;
    logic FB_BUSY = 1'b0;
    logic SWAP_REQ;
    logic SWAP_ACK = 1'b0;
    logic DISP_BANK;
    logic FRAME_DONE;
    logic [15:0] FRAME_CNT;
    logic ERR_TIMEOUT;

    typedef struct {
        logic [FB_ADDR_W:0] addr;
        logic [15:0]        data;
        int                 stall;
    } exp_t;

    exp_t frame_tbl[16];
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int enable_cnt = 0;
    int writes_done = 0;
    int base;

    // Behavioural RTcore state (never reset by RESET_N).
    logic rt_ready_m = 1'b1;
    logic [3:0] rt_pix_m = 4'd0;
    logic [3:0] rt_cap_m = 4'd0;
    int busy_left = 0;
    int model_req_cnt = 0;
    int hang_at = -1;

    assign RT_READY = rt_ready_m;
    assign RT_PIXEL = rt_pix_m;

    rt_frame_sequencer #(
        .H_RES(H_RES),
        .V_RES(V_RES),
        .FB_ADDR_W(FB_ADDR_W)
`ifdef RTSEQ_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP),
        .RT_ENABLE(RT_ENABLE), .RT_X(RT_X), .RT_Y(RT_Y),
        .RT_READY(RT_READY), .RT_PIXEL(RT_PIXEL),
        .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_WDATA(FB_WDATA), .FB_BUSY(FB_BUSY),
        .SWAP_REQ(SWAP_REQ), .SWAP_ACK(SWAP_ACK), .DISP_BANK(DISP_BANK),
        .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT), .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // RTcore model: accepts ENABLE when idle, returns pixel = X after a latency.
    always @(posedge CLK) begin
        if (rt_ready_m && RT_ENABLE) begin
            rt_ready_m    <= 1'b0;
            rt_cap_m      <= RT_X[3:0];
            busy_left     <= (model_req_cnt == hang_at) ? HANG_LAT : RT_LAT;
            model_req_cnt <= model_req_cnt + 1;
        end else if (!rt_ready_m) begin
            if (busy_left == 1) begin
                rt_ready_m <= 1'b1;
                rt_pix_m   <= rt_cap_m;
            end
            busy_left <= busy_left - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pushes the expected writes of one frame from the vector table.
    task automatic applyStimulus(input int f, input bit tmo_lane0);
        exp_t e;
        for (int w = 0; w < 4; w++) begin
            e = frame_tbl[f*4 + w];
            if (tmo_lane0 && w == 0)
                e.data = 16'h321C;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulseStart();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rt_enable"}, RT_ENABLE, 0);
        checkOutput({tag, "_rt_xy"}, {RT_X, RT_Y}, 0);
        checkOutput({tag, "_fb"}, {FB_WE, FB_ADDR, FB_WDATA}, 0);
        checkOutput({tag, "_swap_req"}, SWAP_REQ, 0);
        checkOutput({tag, "_disp_bank"}, DISP_BANK, 0);
        checkOutput({tag, "_frame_done"}, FRAME_DONE, 0);
        checkOutput({tag, "_frame_cnt"}, FRAME_CNT, 0);
        checkOutput({tag, "_err_timeout"}, ERR_TIMEOUT, 0);
    endtask

    task automatic waitEnableCnt(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (enable_cnt >= target) break;
            tick();
        end
        checkOutput("enable_count_reached", enable_cnt >= target, 1);
    endtask

    task automatic waitSwapReq(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (SWAP_REQ) break;
            tick();
        end
        checkOutput("swap_req_seen", SWAP_REQ, 1);
        checkOutput("all_writes_seen", sb.size(), 0);
    endtask

    task automatic ackSwap(input int delay, input logic exp_bank, input logic [15:0] exp_cnt);
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("swap_req_held", {SWAP_REQ, FRAME_DONE}, 2'b10);
        end
        SWAP_ACK = 1'b1;
        tick();
        SWAP_ACK = 1'b0;
        checkOutput("frame_done_pulse", FRAME_DONE, 1);
        checkOutput("disp_bank", DISP_BANK, exp_bank);
        checkOutput("frame_cnt", FRAME_CNT, exp_cnt);
        checkOutput("swap_req_dropped", SWAP_REQ, 0);
        tick();
        checkOutput("frame_done_one_cycle", FRAME_DONE, 0);
    endtask

    // Write monitor: drives FB_BUSY stalls and compares each completed write.
    initial begin
        bit in_write = 0;
        int stall_left = 0;
        forever begin
            @(negedge CLK);
            if (RT_ENABLE) enable_cnt++;
            if (FB_WE) begin
                if (!in_write) begin
                    in_write   = 1;
                    stall_left = (sb.size() > 0) ? sb[0].stall : 0;
                end
                if (stall_left > 0) begin
                    FB_BUSY = 1'b1;
                    stall_left--;
                end else begin
                    FB_BUSY = 1'b0;
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                             FB_ADDR, FB_WDATA);
                    in_write = 0;
                end else begin
                    checkOutput("fb_addr", FB_ADDR, sb[0].addr);
                    checkOutput("fb_wdata", FB_WDATA, sb[0].data);
                    if (FB_BUSY)
                        checkOutput("rt_enable_during_stall", RT_ENABLE, 0);
                    else begin
                        void'(sb.pop_front());
                        in_write = 0;
                        writes_done++;
                    end
                end
            end else begin
                FB_BUSY  = 1'b0;
                in_write = 0;
            end
        end
    end

    initial begin
        // Frame plan: even frames target bank 1, odd frames bank 0; frame 1 stalls word 0.
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 4; w++) begin
                frame_tbl[f*4 + w].addr  = {((f % 2) == 0) ? 1'b1 : 1'b0, 2'(w)};
                frame_tbl[f*4 + w].data  = ((w % 2) == 0) ? 16'h3210 : 16'h7654;
                frame_tbl[f*4 + w].stall = (f == 1 && w == 0) ? 7 : 0;
            end
        end

        repeat (3) tick();
        checkResetOutputs("reset");
        RESET_N = 1'b1;
        tick();

        $display("[TB] full frame into bank 1");
        applyStimulus(0, 0);
        pulseStart();
        waitSwapReq(400);
        applyStimulus(1, 0);
        ackSwap(10, 1'b1, 16'd1);

        $display("[TB] second frame into bank 0 with stalled word 0 and stray SWAP_ACK");
        base = enable_cnt;
        waitEnableCnt(base + 3, 100);
        SWAP_ACK = 1'b1;
        tick();
        SWAP_ACK = 1'b0;
        tick();
        checkOutput("stray_ack_ignored", {DISP_BANK, FRAME_CNT, FRAME_DONE}, {1'b1, 16'd1, 1'b0});
        waitSwapReq(400);
        applyStimulus(2, 0);
        ackSwap(3, 1'b0, 16'd2);

        $display("[TB] STOP at pixel 5");
        base = enable_cnt;
        waitEnableCnt(base + 6, 150);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        waitSwapReq(400);
        ackSwap(2, 1'b1, 16'd3);
        base = enable_cnt;
        repeat (20) tick();
        checkOutput("idle_no_enable", enable_cnt - base, 0);
        checkOutput("idle_outputs", {SWAP_REQ, FB_WE, RT_X, RT_Y}, 0);

        $display("[TB] restart, then reset mid-pixel");
        applyStimulus(3, 0);
        base = enable_cnt;
        pulseStart();
        waitEnableCnt(base + 1, 20);
        checkOutput("restart_xy", {RT_X, RT_Y}, 0);
        hang_at = model_req_cnt;
        waitEnableCnt(base + 2, 40);
        tick();
        RESET_N = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        tick();
        RESET_N = 1'b1;
        applyStimulus(0, 0);
        base = enable_cnt;
        pulseStart();
        for (int i = 0; i < HANG_LAT + 10; i++) begin
            @(negedge CLK);
            if (rt_ready_m) break;
            checkOutput("no_enable_while_rt_busy", RT_ENABLE, 0);
        end
        tick();
        waitEnableCnt(base + 1, 20);
        checkOutput("post_reset_xy", {RT_X, RT_Y}, 0);
        waitSwapReq(400);
        ackSwap(1, 1'b1, 16'd1);

`ifdef RTSEQ_TIMEOUT_EN
        $display("[TB] RTcore timeout on pixel 0");
        RESET_N = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        checkOutput("tmo_err_after_reset", ERR_TIMEOUT, 0);
        applyStimulus(0, 1);
        hang_at = model_req_cnt;
        base = enable_cnt;
        pulseStart();
        waitEnableCnt(base + 1, 20);
        repeat (15) tick();
        checkOutput("tmo_err_before_limit", ERR_TIMEOUT, 0);
        tick();
        checkOutput("tmo_err_at_limit", ERR_TIMEOUT, 1);
        waitSwapReq(800);
        ackSwap(1, 1'b1, 16'd1);
        checkOutput("tmo_err_sticky", ERR_TIMEOUT, 1);
`endif

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
